// File: rtl/sqrt_nr_seq.sv
// Sequential non-restoring integer square root, one root bit per clock.
// Optional round-to-nearest result when SQRT_ROUND_EN is defined.
module sqrt_nr_seq #(
    parameter int WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [WIDTH-1:0]   i_data_in,
    output logic               o_busy,
    output logic               o_done,
    output logic [WIDTH/2-1:0] o_result,
    output logic [WIDTH/2:0]   o_residue
);

    localparam int N  = WIDTH / 2;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [WIDTH-1:0]  r_data;
    logic [N+1:0]      r_rem;
    logic [N-1:0]      r_q;
    logic [KW-1:0]     r_k;
    logic              r_done;
    logic [N-1:0]      r_result;
    logic [N:0]        r_residue;

    logic [1:0]        w_pair;
    logic [N+1:0]      w_rshift;
    logic [N+1:0]      w_rnew;
    logic [N-1:0]      w_qnew;
    logic [N:0]        w_rfix;
    logic [N-1:0]      w_result;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (i_start) w_nextState = ITER;
            ITER:    if (r_k == '0) w_nextState = FIX;
            FIX:     w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        o_busy    = (r_state != IDLE);
        o_done    = r_done;
        o_result  = r_result;
        o_residue = r_residue;
    end

    // Shift in the next radicand bit pair, then subtract or add depending on the sign of R.
    always_comb begin
        w_pair   = r_data[{r_k, 1'b0} +: 2];
        w_rshift = {r_rem[N-1:0], w_pair};
        if (r_rem[N+1]) begin
            w_rnew = w_rshift + {r_q, 2'b11};
        end else begin
            w_rnew = w_rshift - {r_q, 2'b01};
        end
        w_qnew = {r_q[N-2:0], ~w_rnew[N+1]};
    end

    // The corrected remainder is known to be non-negative and below 2^(N+1), so the low bits suffice.
    always_comb begin
        if (r_rem[N+1]) begin
            w_rfix = r_rem[N:0] + {r_q, 1'b1};
        end else begin
            w_rfix = r_rem[N:0];
        end
    end

`ifdef SQRT_ROUND_EN
    always_comb begin
        w_result = r_q;
        if ((w_rfix > {1'b0, r_q}) && (r_q != '1)) begin
            w_result = r_q + N'(1);
        end
    end
`else
    assign w_result = r_q;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data    <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_k       <= '0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_residue <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_data <= i_data_in;
                        r_rem  <= '0;
                        r_q    <= '0;
                        r_k    <= KW'(N - 1);
                    end
                end
                ITER: begin
                    r_rem <= w_rnew;
                    r_q   <= w_qnew;
                    r_k   <= r_k - KW'(1);
                end
                FIX: begin
                    r_rem     <= {1'b0, w_rfix};
                    r_residue <= w_rfix;
                    r_result  <= w_result;
                    r_done    <= 1'b1;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt_nr_seq.sv
// Self-checking bench for sqrt_nr_seq (WIDTH=16) against an arithmetic reference model.
// Build with +define+SQRT_ROUND_EN to check the rounded-result variant.
module tb_sqrt_nr_seq;

    localparam int WIDTH = 16;
    localparam int N     = WIDTH / 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] dataIn = '0;
    logic             busy;
    logic             done;
    logic [N-1:0]     result;
    logic [N:0]       residue;

    int nCompared   = 0;
    int nMismatched = 0;

    sqrt_nr_seq #(.WIDTH(WIDTH)) dut (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_start   (start),
        .i_data_in (dataIn),
        .o_busy    (busy),
        .o_done    (done),
        .o_result  (result),
        .o_residue (residue)
    );

    always #5 clk = ~clk;

    // Reference: floor root by counting up, remainder from plain arithmetic, rounding to nearest.
    function automatic void model(input longint d, output longint expResult, output longint expResidue);
        longint q;
        q = 0;
        while ((q + 1) * (q + 1) <= d) q++;
        expResidue = d - q * q;
        expResult  = q;
`ifdef SQRT_ROUND_EN
        if (d > q * q + q) expResult = q + 1;
        if (expResult > (64'd1 << N) - 1) expResult = (64'd1 << N) - 1;
`endif
    endfunction

    task automatic doStart(input logic [WIDTH-1:0] d);
        start  = 1'b1;
        dataIn = d;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic waitDone(output int edges);
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) break;
        end
        if (!done) edges = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        nCompared++;
        if ({busy, done, result, residue} !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_state: got busy=%0b done=%0b result=%0d residue=%0d, want all 0",
                     busy, done, result, residue);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] vals[$];
        longint expRes, expRem;
        logic [N-1:0] prevResult;
        int edges;
        vals = '{16'd0, 16'd144, 16'd200, 16'd65535, 16'd210, 16'd211, 16'd1, 16'd3, 16'd65024};
        for (int i = 0; i < 25; i++) vals.push_back(WIDTH'($urandom_range(0, 65535)));
        foreach (vals[i]) begin
            model(longint'(vals[i]), expRes, expRem);
            prevResult = result;
            doStart(vals[i]);
            dataIn = WIDTH'($urandom);
            nCompared++;
            if (busy !== 1'b1 || result !== prevResult) begin
                nMismatched++;
                $display("[TB] FAIL busy_after_accept d=%0d: got busy=%0b result=%0d, want busy=1 result=%0d",
                         vals[i], busy, result, prevResult);
            end
            waitDone(edges);
            nCompared++;
            if (edges != N + 1 || busy !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL latency d=%0d: got edges=%0d busy=%0b, want edges=%0d busy=0",
                         vals[i], edges, busy, N + 1);
            end
            nCompared++;
            if (longint'(result) != expRes || longint'(residue) != expRem) begin
                nMismatched++;
                $display("[TB] FAIL sqrt d=%0d: got result=%0d residue=%0d, want result=%0d residue=%0d",
                         vals[i], result, residue, expRes, expRem);
            end
            @(posedge clk);
            #1;
            nCompared++;
            if (done !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL done_pulse d=%0d: got done=%0b, want 0", vals[i], done);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int edges;
        int extraDones;
        doStart(16'd144);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start  = 1'b1;
        dataIn = 16'd9;
        @(posedge clk); #1;
        start  = 1'b0;
        waitDone(edges);
        nCompared++;
        if (edges != N - 2 || result !== N'(12) || residue !== '0) begin
            nMismatched++;
            $display("[TB] FAIL busy_ignore: got edges=%0d result=%0d residue=%0d, want edges=%0d result=12 residue=0",
                     edges, result, residue, N - 2);
        end
        extraDones = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (done || busy) extraDones++;
        end
        nCompared++;
        if (extraDones != 0) begin
            nMismatched++;
            $display("[TB] FAIL busy_ignore_queue: got %0d cycles with done/busy, want 0", extraDones);
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        doStart(16'd144);
        waitDone(edges);
        start  = 1'b1;
        dataIn = 16'd9;
        @(posedge clk); #1;
        start  = 1'b0;
        nCompared++;
        if (busy !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL back_to_back_accept: got busy=%0b, want 1", busy);
        end
        waitDone(edges);
        nCompared++;
        if (edges != N + 1 || result !== N'(3) || residue !== '0) begin
            nMismatched++;
            $display("[TB] FAIL back_to_back: got edges=%0d result=%0d residue=%0d, want edges=%0d result=3 residue=0",
                     edges, result, residue, N + 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int edges;
        int doneSeen;
        doStart(16'd200);
        repeat (3) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        nCompared++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || residue !== '0) begin
            nMismatched++;
            $display("[TB] FAIL abort_reset: got busy=%0b done=%0b result=%0d residue=%0d, want all 0",
                     busy, done, result, residue);
        end
        doneSeen = 0;
        repeat (14) begin
            @(posedge clk); #1;
            if (done || busy) doneSeen++;
        end
        nCompared++;
        if (doneSeen != 0) begin
            nMismatched++;
            $display("[TB] FAIL abort_no_done: got %0d cycles with done/busy, want 0", doneSeen);
        end
        doStart(16'd81);
        waitDone(edges);
        nCompared++;
        if (edges != N + 1 || result !== N'(9) || residue !== '0) begin
            nMismatched++;
            $display("[TB] FAIL after_abort: got edges=%0d result=%0d residue=%0d, want edges=%0d result=9 residue=0",
                     edges, result, residue, N + 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_ignore();
        test_back_to_back();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/sqrt_nr_seq.md
Name: sqrt_nr_seq

Overview:
- Parametrised, self-contained sequential non-restoring integer square root.
- Computes floor(sqrt(data_in)) and remainder for an unsigned WIDTH-bit operand, one root bit per clock.
- Internal add/subtract datapath, so no external adder loop.
- Sits in the arithmetic unit beside the multiplier/divider; driven by a start/busy/done handshake from the control FSM.

Parameters:
- WIDTH, 16, operand width in bits; must be even and >= 4; N = WIDTH/2 root bits.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- data_in  input  WIDTH  unsigned radicand; captured on the accepting edge
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: result/residue are newly valid
- result  output  N  root (floor, or rounded when the option is enabled)
- residue  output  N+1  data_in - floor_root^2, always non-negative

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0, done=0, result=0, residue=0; all internal registers cleared. Applies mid-operation: the operation is aborted and nothing completes.
- State machine: IDLE -> ITER -> FIX -> IDLE.
- IDLE:
  - start=1 at edge E0 captures data_in, clears partial remainder R (signed, N+2 bits) and Q (N bits), loads iteration counter k=N-1, moves to ITER.
  - busy=1 from E0.
- ITER, one iteration per edge E1..EN:
  - R' = (R<<2) | data_in[2k+1:2k].
  - If R>=0: R = R' - ((Q<<2)|1); else R = R' + ((Q<<2)|3).
  - Q = (Q<<1) | ~R_new[sign].
  - k decrements; at k=0 move to FIX.
- FIX, edge E(N+1):
  - If R<0, R = R + ((Q<<1)|1).
  - Load residue=R[N:0] and result=Q (or the rounded value, see option).
  - done=1 and busy=0 for the cycle after E(N+1); return to IDLE.
- Latency: done is visible N+1 edges after the accepting edge (9 edges for WIDTH=16). Throughput is one operation per N+2 cycles.
- start while busy=1 is ignored: no queueing, no effect on the operation in flight.
- start during the done cycle is accepted, because the block is already IDLE.
- result/residue hold their value until the next FIX load or reset. They are unchanged during an in-flight operation.
- data_in is only sampled at E0; changes afterwards have no effect.
- Width rules:
  - Q never exceeds 2^N-1.
  - residue <= 2*Q, so N+1 bits suffice.
  - R needs N+2 bits signed; no intermediate value overflows.

Optional Feature:
- Macro SQRT_ROUND_EN.
- Defined:
  - result = Q+1 when residue > Q (round to nearest), else Q.
  - If Q = 2^N-1 and rounding applies, result saturates to 2^N-1.
  - residue still reports data_in - Q^2 (floor remainder).
- Undefined: result = Q (floor). No extra logic is present.
- Latency is identical in both builds.

Test Plan (WIDTH=16):
- data_in=0, start -> done 9 edges later; result=0, residue=0; busy low in the done cycle.
- data_in=144 -> result=12, residue=0. data_in=200 -> result=14, residue=4.
- data_in=65535 -> result=255, residue=510. With SQRT_ROUND_EN: result=255 (saturated).
- SQRT_ROUND_EN: data_in=210 -> result=14, residue=14. data_in=211 -> result=15, residue=15. Without the macro, both give result=14.
- start with data_in=144, then start with data_in=9 pulsed at E3 -> single done, result=12. Start asserted in the done cycle with data_in=9 -> next done gives result=3, residue=0.
- start with 200, reset asserted at E4 -> busy=0, result=0, residue=0 next cycle, no done pulse. A subsequent start with 81 gives result=9, residue=0.
